// File: rtl/axilite_master_arbiter.sv
`default_nettype none
// ============================================================================
// axilite_master_arbiter - round-robin share of one AXI4-Lite master port
// Optional watchdog: define AXIL_ARB_TIMEOUT_EN.     Revision: 1.0
// ============================================================================
module axilite_master_arbiter #(
  parameter int N_REQ          = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            REQ_VALID,
  input  logic [N_REQ-1:0]            REQ_WRITE,
  input  logic [N_REQ*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [N_REQ*DATA_WIDTH-1:0] REQ_WDATA,
  output logic [N_REQ-1:0]            REQ_READY,
  output logic [N_REQ-1:0]            RSP_VALID,
  output logic [DATA_WIDTH-1:0]       RSP_RDATA,
  output logic [1:0]                  RSP_RESP,
  output logic [$clog2(N_REQ)-1:0]    GRANT_ID,
  output logic                        M_W_EN,
  output logic [ADDR_WIDTH-1:0]       M_W_ADDR,
  output logic [DATA_WIDTH-1:0]       M_W_DATA,
  input  logic                        M_W_DONE,
  input  logic [1:0]                  M_W_RESP,
  output logic                        M_R_EN,
  output logic [ADDR_WIDTH-1:0]       M_R_ADDR,
  input  logic [DATA_WIDTH-1:0]       M_R_DATA,
  input  logic [1:0]                  M_R_RESP,
  input  logic                        M_R_DONE,
  input  logic                        M_BUSY,
  output logic                        TIMEOUT
);
  localparam int IDW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [IDW-1:0]        ptr_q, ptr_d;
  logic [IDW-1:0]        grant_q, grant_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic [N_REQ-1:0]      ready_q, ready_d;

  logic                  found;
  logic [IDW-1:0]        pick;
  logic [IDW-1:0]        idx;
  logic                  done;
  logic [N_REQ-1:0]      rsp_sel;

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;
`endif

  // First valid requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDW'((int'(ptr_q) + k) % N_REQ);
      if (!found && REQ_VALID[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Only the DONE matching the latched direction completes the transfer.
  assign done = write_q ? M_W_DONE : M_R_DONE;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    resp_d  = resp_q;
    ready_d = '0;
`ifdef AXIL_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!M_BUSY && found) begin
          grant_d       = pick;
          ptr_d         = (pick == IDW'(N_REQ - 1)) ? '0 : pick + 1'b1;
          write_d       = REQ_WRITE[pick];
          addr_d        = REQ_ADDR[pick*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d       = REQ_WDATA[pick*DATA_WIDTH +: DATA_WIDTH];
          ready_d[pick] = 1'b1;
`ifdef AXIL_ARB_TIMEOUT_EN
          cnt_d         = '0;
`endif
          state_d       = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (done) begin
          resp_d  = write_q ? M_W_RESP : M_R_RESP;
          rdata_d = write_q ? '0 : M_R_DATA;
          state_d = S_RESP;
        end
`ifdef AXIL_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          resp_d    = 2'b10;
          rdata_d   = '0;
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP:  state_d = S_DRAIN;
      S_DRAIN: if (!M_BUSY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      resp_q  <= '0;
      ready_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      resp_q  <= resp_d;
      ready_q <= ready_d;
    end
  end

`ifdef AXIL_ARB_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end
  assign TIMEOUT = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign TIMEOUT = 1'b0;
`endif

  always_comb begin
    rsp_sel = '0;
    if (state_q == S_RESP) rsp_sel[grant_q] = 1'b1;
  end

  assign REQ_READY = ready_q;
  assign RSP_VALID = rsp_sel;
  assign RSP_RDATA = (state_q == S_RESP) ? rdata_q : '0;
  assign RSP_RESP  = (state_q == S_RESP) ? resp_q : 2'b00;
  assign GRANT_ID  = grant_q;
  assign M_W_EN    = (state_q == S_ISSUE) && write_q;
  assign M_R_EN    = (state_q == S_ISSUE) && !write_q;
  assign M_W_ADDR  = addr_q;
  assign M_R_ADDR  = addr_q;
  assign M_W_DATA  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_axilite_master_arbiter.sv
`default_nettype none
// ============================================================================
// tb_axilite_master_arbiter - scoreboard bench with a behavioural slave model
// Revision: 1.0
// ============================================================================
module tb_axilite_master_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  REQ_VALID, REQ_WRITE, REQ_READY, RSP_VALID;
  logic [N*AW-1:0] REQ_ADDR;
  logic [N*DW-1:0] REQ_WDATA;
  logic [DW-1:0] RSP_RDATA, M_W_DATA, M_R_DATA;
  logic [1:0]    RSP_RESP, M_W_RESP, M_R_RESP;
  logic [$clog2(N)-1:0] GRANT_ID;
  logic          M_W_EN, M_W_DONE, M_R_EN, M_R_DONE, M_BUSY, TIMEOUT;
  logic [AW-1:0] M_W_ADDR, M_R_ADDR;

  always #5 clock = ~clock;

  axilite_master_arbiter #(
    .N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .REQ_VALID(REQ_VALID), .REQ_WRITE(REQ_WRITE), .REQ_ADDR(REQ_ADDR),
    .REQ_WDATA(REQ_WDATA), .REQ_READY(REQ_READY), .RSP_VALID(RSP_VALID),
    .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP), .GRANT_ID(GRANT_ID),
    .M_W_EN(M_W_EN), .M_W_ADDR(M_W_ADDR), .M_W_DATA(M_W_DATA),
    .M_W_DONE(M_W_DONE), .M_W_RESP(M_W_RESP),
    .M_R_EN(M_R_EN), .M_R_ADDR(M_R_ADDR), .M_R_DATA(M_R_DATA),
    .M_R_RESP(M_R_RESP), .M_R_DONE(M_R_DONE),
    .M_BUSY(M_BUSY), .TIMEOUT(TIMEOUT)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_log[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] mem     [logic [31:0]];
  bit          stall = 1'b0;
  bit          cur_w [N];
  logic [31:0] cur_a [N];
  logic [31:0] cur_d [N];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [159:0] all_outputs();
    return {REQ_READY, RSP_VALID, RSP_RDATA, RSP_RESP, GRANT_ID, M_W_EN,
            M_W_ADDR, M_W_DATA, M_R_EN, M_R_ADDR, TIMEOUT};
  endfunction

  // One nibble per grant recorded since index 'base'.
  function automatic logic [31:0] log_code(input int base);
    logic [31:0] c = '0;
    for (int j = base; j < grant_log.size(); j++) c = (c << 4) | 32'(grant_log[j]);
    return c;
  endfunction

  // Slave rule: addresses at 0xF0000000 and above answer DECERR, no storage.
  function automatic bit is_decerr(input logic [31:0] a);
    return a >= 32'hF000_0000;
  endfunction

  // Grant monitor: spec-level round robin over the requests seen one cycle earlier.
  initial begin : grant_mon
    logic [N-1:0] prev_valid;
    logic [N-1:0] oh;
    int ptr_model;
    int g;
    prev_valid = '0;
    ptr_model  = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        ptr_model = 0;
      end else if (REQ_READY != '0) begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && prev_valid[(ptr_model + k) % N]) g = (ptr_model + k) % N;
        if (g < 0) begin
          check("grant_without_request", 160'(REQ_READY), 160'd0);
        end else begin
          oh = '0;
          oh[g] = 1'b1;
          check("req_ready", 160'(REQ_READY), 160'(oh));
          check("grant_id", 160'(GRANT_ID), 160'(g));
          if (cur_w[g])
            check("write_issue", {M_W_EN, M_R_EN, M_W_ADDR, M_W_DATA}, {2'b10, cur_a[g], cur_d[g]});
          else
            check("read_issue", {M_W_EN, M_R_EN, M_R_ADDR}, {2'b01, cur_a[g]});
          grant_log.push_back(g);
          ptr_model = (g + 1) % N;
        end
      end
      prev_valid = REQ_VALID;
    end
  end

  // Response monitor: pops the oldest expectation for the responding requester.
  initial begin : rsp_mon
    int id;
    int hit;
    forever begin
      @(negedge clock);
      if (!reset && RSP_VALID != '0) begin
        id = -1;
        for (int k = 0; k < N; k++) if (RSP_VALID[k]) id = k;
        check("rsp_onehot", 160'($countones(RSP_VALID)), 160'd1);
        hit = -1;
        foreach (exp_q[j]) if (hit < 0 && exp_q[j].id == id) hit = j;
        if (hit < 0) begin
          check("unexpected_rsp", 160'(RSP_VALID), 160'd0);
        end else begin
          check($sformatf("rsp%0d", id), {RSP_RESP, RSP_RDATA},
                {exp_q[hit].resp, exp_q[hit].data});
          exp_q.delete(hit);
        end
      end
    end
  end

  // Slave-side master model: random latency, stray opposite-direction DONEs.
  initial begin : master
    bit          is_w;
    logic [31:0] a, d, rd;
    logic [1:0]  rsp;
    int          lat;
    M_W_DONE = 1'b0; M_R_DONE = 1'b0; M_W_RESP = 2'b00; M_R_RESP = 2'b00;
    M_R_DATA = '0;   M_BUSY   = 1'b0;
    forever begin
      @(posedge clock); #2;
      if (reset) begin
        mem.delete();
      end else if (M_W_EN || M_R_EN) begin
        if (stall) begin
          while (M_W_EN || M_R_EN) begin @(posedge clock); #2; end
        end else begin
          is_w = M_W_EN;
          a    = is_w ? M_W_ADDR : M_R_ADDR;
          d    = M_W_DATA;
          M_BUSY = 1'b1;
          lat  = $urandom_range(0, 3);
          for (int c = 0; c < lat; c++) begin
            if ($urandom_range(0, 1) == 1) begin
              if (is_w) begin M_R_DONE = 1'b1; M_R_RESP = 2'b11; M_R_DATA = $urandom; end
              else      begin M_W_DONE = 1'b1; M_W_RESP = 2'b11; end
            end
            @(posedge clock); #2;
            M_R_DONE = 1'b0; M_W_DONE = 1'b0;
            check("en_hold", {M_W_EN, M_R_EN, (is_w ? M_W_ADDR : M_R_ADDR), (is_w ? M_W_DATA : 32'h0)},
                  {is_w, !is_w, a, (is_w ? d : 32'h0)});
          end
          rd  = '0;
          rsp = 2'b00;
          if (is_decerr(a))     rsp = 2'b11;
          else if (is_w)        mem[a] = d;
          else if (mem.exists(a)) rd = mem[a];
          if (is_w) begin M_W_DONE = 1'b1; M_W_RESP = rsp; M_R_DATA = $urandom; end
          else      begin M_R_DONE = 1'b1; M_R_RESP = rsp; M_R_DATA = rd; end
          @(posedge clock); #2;
          M_W_DONE = 1'b0; M_R_DONE = 1'b0; M_W_RESP = 2'b00; M_R_RESP = 2'b00; M_R_DATA = '0;
          repeat ($urandom_range(0, 2)) begin @(posedge clock); #2; end
          M_BUSY = 1'b0;
        end
      end
    end
  end

  task automatic present(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
    cur_w[i] = w; cur_a[i] = a; cur_d[i] = d;
    REQ_WRITE[i] = w;
    REQ_ADDR[i*AW +: AW]  = a;
    REQ_WDATA[i*DW +: DW] = d;
    REQ_VALID[i] = 1'b1;
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    while (1) begin
      @(negedge clock);
      if (REQ_READY[i]) break;
      if (++n > 3000) begin check($sformatf("ready_wait%0d", i), 160'd0, 160'd1); break; end
    end
    @(posedge clock); #1;
    REQ_VALID[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i);
    int n = 0;
    while (1) begin
      @(negedge clock);
      if (RSP_VALID[i]) break;
      if (++n > 3000) begin check($sformatf("rsp_wait%0d", i), 160'd0, 160'd1); break; end
    end
    @(posedge clock); #1;
  endtask

  // Issues one transaction and records the response the slave rules predict.
  task automatic do_txn(input int i, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.id = i; e.data = '0; e.resp = 2'b00;
    if (is_decerr(a))           e.resp = 2'b11;
    else if (w)                 ref_mem[a] = d;
    else if (ref_mem.exists(a)) e.data = ref_mem[a];
    exp_q.push_back(e);
    present(i, w, a, d);
    wait_ready(i);
    wait_rsp(i);
  endtask

  task automatic rand_thread(input int i);
    logic [31:0] a;
    repeat (12) begin
      repeat ($urandom_range(0, 4)) begin @(posedge clock); #1; end
      if ($urandom_range(0, 7) == 0) a = 32'hF000_0000 + 32'(i * 256);
      else a = 32'h2000_0000 + 32'(i * 256) + 32'(4 * $urandom_range(0, 3));
      do_txn(i, 1'($urandom_range(0, 1)), a, $urandom);
    end
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: run did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int base;
    int n;
    REQ_VALID = '0; REQ_WRITE = '0; REQ_ADDR = '0; REQ_WDATA = '0;
    for (int k = 0; k < N; k++) begin cur_w[k] = 1'b0; cur_a[k] = '0; cur_d[k] = '0; end
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("reset_outputs", all_outputs(), 160'd0);
    @(posedge clock); #1;

    // Simultaneous requests from a fresh pointer grant in index order.
    base = grant_log.size();
    for (int k = 0; k < N; k++) begin
      fork
        automatic int kk = k;
        do_txn(kk, 1'b1, 32'h0001_0000 + 32'(kk) * 32'h4000, 32'hA000_0000 + 32'(kk));
      join_none
    end
    wait fork;
    check("contention_order", 160'(log_code(base)), 160'h0123);
    for (int k = 0; k < N; k++) do_txn(3, 1'b0, 32'h0001_0000 + 32'(k) * 32'h4000, 32'h0);

    do_txn(0, 1'b1, 32'h0001_0000, 32'hDEAD_BEEF);
    do_txn(1, 1'b0, 32'h0001_0000, 32'h0);

    // Pointer is 2 here: a held requester 0 alternates with requester 2.
    base = grant_log.size();
    fork
      begin repeat (3) do_txn(0, 1'b1, 32'h0000_0020, $urandom); end
      begin repeat (3) do_txn(2, 1'b1, 32'h0000_0028, $urandom); end
    join
    check("fairness_order", 160'(log_code(base)), 160'h202020);

    do_txn(2, 1'b0, 32'h0000_0028, 32'h0);
    base = grant_log.size();
    fork
      do_txn(1, 1'b0, 32'h0000_0020, 32'h0);
      do_txn(3, 1'b0, 32'h0001_C000, 32'h0);
    join
    check("wrap_order", 160'(log_code(base)), 160'h31);

    for (int k = 0; k < N; k++) begin
      fork
        automatic int kk = k;
        rand_thread(kk);
      join_none
    end
    wait fork;

    // Reset while a read is outstanding: everything clears, no response.
    stall = 1'b1;
    present(2, 1'b0, 32'h0001_8000, 32'h0);
    wait_ready(2);
    check("rd_en_before_reset", 160'(M_R_EN), 160'd1);
    reset = 1'b1;
    ref_mem.delete();
    @(posedge clock);
    @(negedge clock);
    check("outputs_after_reset", all_outputs(), 160'd0);
    repeat (2) begin
      @(negedge clock);
      check("no_rsp_in_reset", 160'(RSP_VALID), 160'd0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    stall = 1'b0;
    @(posedge clock); #1;
    do_txn(2, 1'b0, 32'h0001_8000, 32'h0);

`ifdef AXIL_ARB_TIMEOUT_EN
    begin
      exp_t e;
      stall = 1'b1;
      e.id = 1; e.data = '0; e.resp = 2'b10;
      exp_q.push_back(e);
      present(1, 1'b0, 32'h2000_0100, 32'h0);
      wait_ready(1);
      n = 1;
      for (int c = 0; c < 100; c++) begin
        @(negedge clock);
        if (M_R_EN) n++;
        else break;
      end
      check("timeout_en_cycles", 160'(n), 160'(TO));
      check("timeout_flag", {TIMEOUT, M_R_EN, M_W_EN}, 160'b100);
      @(posedge clock); #1;
      stall = 1'b0;
      repeat (3) begin @(posedge clock); #1; end
      do_txn(1, 1'b1, 32'h2000_0104, 32'h1234_5678);
      check("timeout_sticky", 160'(TIMEOUT), 160'd1);
    end
`else
    n = 0;
    check("timeout_tied_low", 160'(TIMEOUT), 160'(n));
`endif

    repeat (5) @(negedge clock);
    check("pending_responses", 160'(exp_q.size()), 160'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
